// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, stop bit,
// each held for BIT_CYCLES clocks. Line idles high; all outputs registered.
module serial_frame_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned   IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_adv;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic             dout_q, dout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             first_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The next bit to send always sits at the outgoing end of the shift register;
  // it is presented on dout and shifted out on the same edge.
  always_comb begin
    bit_end   = (cnt_q == CNT_LAST);
    cnt_adv   = bit_end ? '0 : cnt_q + CW'(1);
    first_bit = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
    sh_next   = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din_valid && ready_q) begin
          state_d = START;
          sh_d    = din;
          cnt_d   = '0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          dout_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      START: begin
        cnt_d = cnt_adv;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          dout_d  = first_bit;
          sh_d    = sh_next;
        end
      end
      DATA: begin
        cnt_d = cnt_adv;
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            dout_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IW'(1);
            dout_d = first_bit;
            sh_d   = sh_next;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_adv;
        if (bit_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign din_ready = ready_q;
  assign dout      = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: three instances (LSB/BC=4, MSB/BC=4, LSB/BC=1)
// with queued expected words and per-instance monitors rebuilding the line waveform.
module tb_serial_frame_tx;

  localparam int unsigned W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din [3];
  logic       din_valid [3];
  logic       din_ready [3];
  logic       dout [3];
  logic       busy [3];
  logic       done [3];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .dout(dout[0]), .busy(busy[0]), .done(done[0]));
  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .dout(dout[1]), .busy(busy[1]), .done(done[1]));
  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .LSB_FIRST(1'b1)) u_fast (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .dout(dout[2]), .busy(busy[2]), .done(done[2]));

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Frame bit b of a word: 0 = start, 1..W = data in send order, W+1 = stop.
  function automatic logic ref_bit(input logic [7:0] d, input bit lsb, input int unsigned b);
    if (b == 0) return 1'b0;
    if (b == W + 1) return 1'b1;
    return lsb ? d[b-1] : d[W-b];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int unsigned BC  = (g == 2) ? 1 : 4;
    localparam bit          LSB = (g != 1);
    initial begin
      logic [7:0]  d;
      logic [63:0] got_w, exp_w;
      int unsigned bad;
      bit          aborted;
      forever begin
        @(negedge clk);
        if (rst_n && busy[g] === 1'b1) begin
          d = 8'h00;
          if (exp_q[g].size() == 0)
            check(1'b0, $sformatf("unexpected_frame%0d", g), 64'd1, 64'd0);
          else
            d = exp_q[g].pop_front();
          got_w = '0; exp_w = '0; bad = 0; aborted = 1'b0;
          for (int unsigned j = 0; j < (W + 2) * BC; j++) begin
            if (j != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            got_w[j] = dout[g];
            exp_w[j] = ref_bit(d, LSB, j / BC);
            if (busy[g] !== 1'b1 || done[g] !== 1'b0 || din_ready[g] !== 1'b0) bad++;
          end
          if (!aborted) begin
            check(got_w == exp_w, $sformatf("frame%0d_%0h", g, d), got_w, exp_w);
            check(bad == 0, $sformatf("inframe_flags%0d", g), 64'(bad), 64'd0);
            @(negedge clk);
            if (rst_n)
              check({done[g], busy[g], dout[g], din_ready[g]} == 4'b1011,
                    $sformatf("end_of_frame%0d", g),
                    {60'd0, done[g], busy[g], dout[g], din_ready[g]}, 64'hB);
          end
        end else if (rst_n && done[g] === 1'b1) begin
          check(1'b0, $sformatf("stray_done%0d", g), 64'd1, 64'd0);
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] d, output int unsigned acc);
    int unsigned t;
    t = 0;
    din[g] = d;
    din_valid[g] = 1'b1;
    while (din_ready[g] !== 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    if (t >= 500) begin
      check(1'b0, $sformatf("accept_timeout%0d", g), 64'(t), 64'd0);
      din_valid[g] = 1'b0;
      return;
    end
    exp_q[g].push_back(d);
    @(posedge clk);
    #1;
    din_valid[g] = 1'b0;
    din[g] = 8'($urandom);
  endtask

  initial begin
    int unsigned a1, a2;
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      din_valid[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check({dout[i], busy[i], done[i], din_ready[i]} == 4'b1000, $sformatf("reset_state%0d", i),
            {60'd0, dout[i], busy[i], done[i], din_ready[i]}, 64'h8);
    rst_n = 1'b1;
    @(negedge clk);
    check(din_ready[0] == 1'b1, "ready_after_reset", {63'd0, din_ready[0]}, 64'd1);

    send(0, 8'hA5, a1);
    send(1, 8'h01, a1);
    send(2, 8'h81, a1);
    repeat (50) @(negedge clk);

    send(0, 8'h3C, a1);
    send(0, 8'hC3, a2);
    check(a2 - a1 == (W + 2) * 4 + 1, "b2b_spacing", 64'(a2 - a1), 64'((W + 2) * 4 + 1));
    repeat (50) @(negedge clk);

    send(0, 8'h96, a1);
    repeat (10) @(negedge clk);
    din[0] = 8'hFF;
    din_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    din_valid[0] = 1'b0;
    repeat (40) @(negedge clk);

    send(0, 8'hE7, a1);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({dout[0], busy[0], din_ready[0], done[0]} == 4'b1000, "reset_midframe",
          {60'd0, dout[0], busy[0], din_ready[0], done[0]}, 64'h8);
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h5A, a1);
    repeat (50) @(negedge clk);

    fork
      begin
        int unsigned t0;
        for (int i = 0; i < 6; i++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          send(0, 8'($urandom), t0);
        end
      end
      begin
        int unsigned t1;
        for (int k = 0; k < 6; k++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          send(1, 8'($urandom), t1);
        end
      end
      begin
        int unsigned t2;
        for (int m = 0; m < 6; m++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          send(2, 8'($urandom), t2);
        end
      end
    join
    repeat (60) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check(exp_q[i].size() == 0, $sformatf("drained%0d", i), 64'(exp_q[i].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
